// File: rtl/ram_window_reader_if.sv
// Read-out word stream of ram_window_reader: valid/ready channel with an end-of-window marker.
interface ram_window_reader_if #(
  parameter int P_NBITS_DATA = 42
);
  logic [P_NBITS_DATA-1:0] q;
  logic                    q_valid;
  logic                    q_ready;
  logic                    q_last;

  modport master (
    output q,
    output q_valid,
    output q_last,
    input  q_ready
  );

  modport slave (
    input  q,
    input  q_valid,
    input  q_last,
    output q_ready
  );
endinterface

// File: rtl/ram_window_reader.sv
// Circular sample buffer that, on a trigger, streams back the newest n_pre samples oldest-first
// through a synchronous RAM read feeding a 2-entry skid buffer.
module ram_window_reader #(
  parameter int P_NBITS_DATA = 42,
  parameter int P_NBITS_ADDR = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr,
  input  logic [P_NBITS_DATA-1:0] d,
  input  logic [P_NBITS_ADDR-1:0] n_pre,
  input  logic                    trig,
  ram_window_reader_if.master     q_bus,
  output logic                    busy,
  output logic                    trig_err,
  output logic                    dropped
);

  localparam int DEPTH = 1 << P_NBITS_ADDR;
  localparam logic [P_NBITS_ADDR:0]   FILL_MAX = {1'b1, {P_NBITS_ADDR{1'b0}}};
  localparam logic [P_NBITS_ADDR-1:0] ADDR_ONE = {{(P_NBITS_ADDR-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, READ} state_t;

  state_t state, state_next;

  logic [P_NBITS_DATA-1:0] mem [DEPTH];

  logic [P_NBITS_ADDR-1:0] wptr;
  logic [P_NBITS_ADDR:0]   fill;
  logic [P_NBITS_ADDR-1:0] rptr;
  logic [P_NBITS_ADDR-1:0] issue_left;

  logic                    write_en;
  logic [P_NBITS_ADDR:0]   fill_eff;
  logic [P_NBITS_ADDR-1:0] wptr_eff;
  logic [P_NBITS_ADDR:0]   n_pre_ext;
  logic [P_NBITS_ADDR:0]   len;

  logic                    start;
  logic                    reject;
  logic                    rd_en;
  logic                    pop;
  logic [1:0]              occ;

  logic [P_NBITS_DATA-1:0] rd_data;
  logic                    rd_last;
  logic                    inflight;

  logic [1:0]              cnt;
  logic [P_NBITS_DATA-1:0] slot0_data;
  logic [P_NBITS_DATA-1:0] slot1_data;
  logic                    slot0_last;
  logic                    slot1_last;
  logic                    q_valid_int;

  assign q_valid_int   = (cnt != 2'd0);
  assign q_bus.q       = slot0_data;
  assign q_bus.q_valid = q_valid_int;
  assign q_bus.q_last  = q_valid_int & slot0_last;
  assign busy          = (state == READ);
  assign pop           = q_valid_int & q_bus.q_ready;
  assign occ           = cnt + {1'b0, inflight};

  // Window length counts a sample written on the trigger cycle itself.
  always_comb begin
    write_en  = (state == IDLE) && wr;
    fill_eff  = fill;
    wptr_eff  = wptr;
    if (write_en) begin
      wptr_eff = wptr + 1'b1;
      if (fill != FILL_MAX) begin
        fill_eff = fill + 1'b1;
      end
    end
    n_pre_ext = {1'b0, n_pre};
    len       = (n_pre_ext < fill_eff) ? n_pre_ext : fill_eff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Reads are only issued while the skid buffer can absorb the word still in flight.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    reject     = 1'b0;
    rd_en      = 1'b0;
    case (state)
      IDLE: begin
        if (trig) begin
          if (len == '0) begin
            reject = 1'b1;
          end else begin
            start      = 1'b1;
            state_next = READ;
          end
        end
      end
      READ: begin
        if ((issue_left != '0) && ((occ < 2'd2) || ((occ == 2'd2) && pop))) begin
          rd_en = 1'b1;
        end
        if (pop && slot0_last) begin
          state_next = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      fill <= '0;
    end else if (write_en) begin
      wptr <= wptr_eff;
      fill <= fill_eff;
    end
  end

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[wptr] <= d;
    end
    if (rd_en) begin
      rd_data <= mem[rptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr       <= '0;
      issue_left <= '0;
      inflight   <= 1'b0;
      rd_last    <= 1'b0;
    end else begin
      inflight <= rd_en;
      rd_last  <= rd_en && (issue_left == ADDR_ONE);
      if (start) begin
        rptr       <= wptr_eff - len[P_NBITS_ADDR-1:0];
        issue_left <= len[P_NBITS_ADDR-1:0];
      end else if (rd_en) begin
        rptr       <= rptr + 1'b1;
        issue_left <= issue_left - 1'b1;
      end
    end
  end

  // Slot 0 is the presented word; slot 1 only fills when the consumer stalls with a read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 2'd0;
      slot0_data <= '0;
      slot0_last <= 1'b0;
      slot1_data <= '0;
      slot1_last <= 1'b0;
    end else begin
      case (cnt)
        2'd0: begin
          if (inflight) begin
            slot0_data <= rd_data;
            slot0_last <= rd_last;
            cnt        <= 2'd1;
          end
        end
        2'd1: begin
          if (pop && inflight) begin
            slot0_data <= rd_data;
            slot0_last <= rd_last;
          end else if (pop) begin
            cnt <= 2'd0;
          end else if (inflight) begin
            slot1_data <= rd_data;
            slot1_last <= rd_last;
            cnt        <= 2'd2;
          end
        end
        2'd2: begin
          if (pop) begin
            slot0_data <= slot1_data;
            slot0_last <= slot1_last;
            if (inflight) begin
              slot1_data <= rd_data;
              slot1_last <= rd_last;
            end else begin
              cnt <= 2'd1;
            end
          end
        end
        default: begin
          cnt <= 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_err <= 1'b0;
      dropped  <= 1'b0;
    end else begin
      trig_err <= reject;
      dropped  <= (state == READ) && wr;
    end
  end

endmodule

// File: tb/tb_ram_window_reader.sv
// Bench for ram_window_reader: directed scenarios plus random windows, checked against a
// model that keeps the full accepted-sample history and slices the expected window from it.
module tb_ram_window_reader;

  localparam int W      = 42;
  localparam int ABIG   = 9;
  localparam int ASMALL = 3;

  logic            clk     = 1'b0;
  logic            rst_n   = 1'b0;
  logic            wr      = 1'b0;
  logic [W-1:0]    d       = '0;
  logic [ABIG-1:0] n_pre   = '0;
  logic            trig    = 1'b0;
  logic            q_ready = 1'b0;
  logic            sel     = 1'b0;

  logic busy_b, err_b, drop_b;
  logic busy_s, err_s, drop_s;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] hist [$];

  ram_window_reader_if #(.P_NBITS_DATA(W)) bus_b ();
  ram_window_reader_if #(.P_NBITS_DATA(W)) bus_s ();

  assign bus_b.q_ready = q_ready;
  assign bus_s.q_ready = q_ready;

  ram_window_reader #(.P_NBITS_DATA(W), .P_NBITS_ADDR(ABIG)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .d(d), .n_pre(n_pre), .trig(trig),
    .q_bus(bus_b), .busy(busy_b), .trig_err(err_b), .dropped(drop_b)
  );

  ram_window_reader #(.P_NBITS_DATA(W), .P_NBITS_ADDR(ASMALL)) dut_small (
    .clk(clk), .rst_n(rst_n), .wr(wr), .d(d), .n_pre(n_pre[ASMALL-1:0]), .trig(trig),
    .q_bus(bus_s), .busy(busy_s), .trig_err(err_s), .dropped(drop_s)
  );

  logic [W-1:0] obs_q;
  logic         obs_valid, obs_last, obs_busy, obs_err, obs_drop;

  assign obs_q     = sel ? bus_s.q       : bus_b.q;
  assign obs_valid = sel ? bus_s.q_valid : bus_b.q_valid;
  assign obs_last  = sel ? bus_s.q_last  : bus_b.q_last;
  assign obs_busy  = sel ? busy_s        : busy_b;
  assign obs_err   = sel ? err_s         : err_b;
  assign obs_drop  = sel ? drop_s        : drop_b;

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: time limit reached before the sequence ended");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [W-1:0] randData();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[W-1:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkFlag(input string tag, input logic obs, input logic exp);
    checkOutput(tag, {{(W-1){1'b0}}, obs}, {{(W-1){1'b0}}, exp});
  endtask

  task automatic applyStimulus(input logic w, input logic [W-1:0] dv, input logic t,
                               input logic [ABIG-1:0] np, input logic rdy);
    wr      = w;
    d       = dv;
    trig    = t;
    n_pre   = np;
    q_ready = rdy;
  endtask

  task automatic doReset();
    @(negedge clk);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hist.delete();
  endtask

  task automatic writeSample(input logic [W-1:0] dv);
    @(negedge clk);
    applyStimulus(1'b1, dv, 1'b0, n_pre, 1'b0);
    hist.push_back(dv);
  endtask

  // mode: 0 = ready always high, 1 = ready 1,0,1,0..., 2 = random ready.
  // disturb: hold ready low for 6 cycles while pulsing wr three times and trig once.
  task automatic runWindow(input logic [ABIG-1:0] np, input logic wr_trig, input logic [W-1:0] dv,
                           input int mode, input logic disturb);
    int           depth, np_eff, fill, len, idx, c;
    logic [W-1:0] exp_q [$];
    logic         stall, held_last, prev_wr, rdy, wv, tv;
    logic [W-1:0] held_q;

    if (wr_trig) hist.push_back(dv);
    depth  = sel ? (1 << ASMALL) : (1 << ABIG);
    np_eff = sel ? int'(np[ASMALL-1:0]) : int'(np);
    fill   = (hist.size() < depth) ? hist.size() : depth;
    len    = (np_eff < fill) ? np_eff : fill;
    for (int k = 0; k < len; k++) exp_q.push_back(hist[hist.size() - len + k]);

    @(negedge clk);
    applyStimulus(wr_trig, dv, 1'b1, np, 1'b0);

    if (len == 0) begin
      @(negedge clk);
      applyStimulus(1'b0, '0, 1'b0, np, 1'b0);
      checkFlag("trig_err_pulse", obs_err, 1'b1);
      checkFlag("busy_after_reject", obs_busy, 1'b0);
      @(negedge clk);
      checkFlag("trig_err_single", obs_err, 1'b0);
      checkFlag("valid_after_reject", obs_valid, 1'b0);
      checkFlag("busy_after_reject2", obs_busy, 1'b0);
      return;
    end

    idx = 0; c = 0; stall = 1'b0; prev_wr = 1'b0; held_q = '0; held_last = 1'b0;
    while (idx < len && c < 4 * len + 20) begin
      @(negedge clk);
      c++;
      if (c == 1) checkFlag("busy_rise", obs_busy, 1'b1);
      checkFlag("dropped", obs_drop, prev_wr);
      checkFlag("no_trig_err_in_read", obs_err, 1'b0);
      if (stall) begin
        checkFlag("stall_valid", obs_valid, 1'b1);
        checkOutput("stall_q", obs_q, held_q);
        checkFlag("stall_last", obs_last, held_last);
      end
      if (idx == 0 && c >= 3) checkFlag("first_valid_latency", obs_valid, 1'b1);
      if (mode == 0 && idx > 0 && !disturb) checkFlag("no_bubble", obs_valid, 1'b1);

      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 1) : ($urandom_range(0, 1) == 1);
      wv  = 1'b0;
      tv  = 1'b0;
      if (disturb && c <= 6) begin
        rdy = 1'b0;
        wv  = (c % 2 == 1);
        tv  = (c == 4);
      end
      if (obs_valid && rdy) begin
        checkOutput("q_data", obs_q, exp_q[idx]);
        checkFlag("q_last", obs_last, idx == len - 1);
        idx++;
      end
      stall     = obs_valid && !rdy;
      held_q    = obs_q;
      held_last = obs_last;
      prev_wr   = wv;
      applyStimulus(wv, randData(), tv, np, rdy);
    end
    checkFlag("window_complete", idx == len, 1'b1);

    @(negedge clk);
    applyStimulus(1'b0, '0, 1'b0, np, 1'b0);
    checkFlag("busy_fall", obs_busy, 1'b0);
    checkFlag("valid_after_window", obs_valid, 1'b0);
    checkFlag("dropped_end", obs_drop, prev_wr);
  endtask

  initial begin
    logic [ABIG-1:0] np;

    // Reset state
    sel = 1'b0;
    doReset();
    @(negedge clk);
    checkFlag("reset_q_valid", obs_valid, 1'b0);
    checkFlag("reset_q_last", obs_last, 1'b0);
    checkFlag("reset_busy", obs_busy, 1'b0);
    checkFlag("reset_trig_err", obs_err, 1'b0);
    checkFlag("reset_dropped", obs_drop, 1'b0);
    checkOutput("reset_q", obs_q, '0);

    // Basic window, then trigger concurrent with a write
    for (int i = 1; i <= 10; i++) writeSample(W'(i));
    runWindow(ABIG'(4), 1'b0, '0, 0, 1'b0);
    doReset();
    for (int i = 1; i <= 10; i++) writeSample(W'(i));
    runWindow(ABIG'(4), 1'b1, W'(11), 0, 1'b0);

    // Backpressure with alternating ready
    doReset();
    for (int i = 0; i < 12; i++) writeSample(randData());
    runWindow(ABIG'(8), 1'b0, '0, 1, 1'b0);

    // Clipping to fill, and rejection on an empty buffer
    doReset();
    for (int i = 1; i <= 3; i++) writeSample(W'(i));
    runWindow(ABIG'(6), 1'b0, '0, 0, 1'b0);
    doReset();
    runWindow(ABIG'(5), 1'b0, '0, 0, 1'b0);

    // Address wrap on the depth-8 instance
    sel = 1'b1;
    doReset();
    for (int i = 1; i <= 20; i++) writeSample(W'(i));
    runWindow(ABIG'(7), 1'b0, '0, 0, 1'b0);
    writeSample(W'(21));
    writeSample(W'(22));
    runWindow(ABIG'(3), 1'b0, '0, 0, 1'b0);

    // Writes and a second trigger during read-out are discarded
    sel = 1'b0;
    doReset();
    for (int i = 0; i < 6; i++) writeSample(randData());
    runWindow(ABIG'(4), 1'b0, '0, 0, 1'b1);
    writeSample(randData());
    writeSample(randData());
    runWindow(ABIG'(5), 1'b0, '0, 2, 1'b0);

    // Reset in the middle of a read-out
    writeSample(randData());
    @(negedge clk);
    applyStimulus(1'b0, '0, 1'b1, ABIG'(1), 1'b0);
    repeat (3) begin
      @(negedge clk);
      applyStimulus(1'b0, '0, 1'b0, ABIG'(1), 1'b0);
    end
    checkFlag("pre_reset_valid", obs_valid, 1'b1);
    checkFlag("pre_reset_last", obs_last, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkFlag("async_reset_valid", obs_valid, 1'b0);
    checkFlag("async_reset_busy", obs_busy, 1'b0);
    checkFlag("async_reset_last", obs_last, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    hist.delete();
    runWindow(ABIG'(5), 1'b0, '0, 0, 1'b0);

    // Random windows on both depths
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      doReset();
      for (int it = 0; it < 12; it++) begin
        int nw;
        nw = $urandom_range(0, 12);
        for (int i = 0; i < nw; i++) writeSample(randData());
        np = ABIG'($urandom_range(0, 20));
        runWindow(np, $urandom_range(0, 1) == 1, randData(), $urandom_range(0, 2),
                  $urandom_range(0, 3) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_window_reader.md
Name: ram_window_reader

Overview:
Circular sample buffer with a triggered read-out engine. It is the read-side companion to the ram_delay line on the same sample stream (wr/d).
- Continuously writes the incoming stream into a 2^P_NBITS_ADDR-deep RAM.
- On a trigger, streams back the most recent n_pre samples, oldest first, over a valid/ready interface.
- Sits between the sample pipeline and the readout/DAQ logic.

Parameters:
P_NBITS_DATA, 42, sample width
P_NBITS_ADDR, 9, RAM address width; depth = 2^P_NBITS_ADDR

Ports:
clk      input   1             clock, all logic on rising edge
rst_n    input   1             asynchronous, active-low reset
wr       input   1             sample write strobe
d        input   P_NBITS_DATA  sample data
n_pre    input   P_NBITS_ADDR  requested window length, sampled on trig
trig     input   1             single-cycle read-out request
q        output  P_NBITS_DATA  read-out data
q_valid  output  1             q holds a valid word
q_ready  input   1             consumer accepts q
q_last   output  1             q is the final word of the window
busy     output  1             read-out in progress
trig_err output  1             1-cycle pulse: trig rejected
dropped  output  1             1-cycle pulse: wr ignored during read-out

Behaviour:
- Single clock; reset is asynchronous and active-low (rst_n).
- Reset values:
  - q_valid=0, q_last=0, busy=0, trig_err=0, dropped=0, q=0.
  - wptr=0, fill=0, state=IDLE.
  - RAM contents are not reset.
- Reset asserted mid read-out aborts it immediately (q_valid=0 asynchronously). No partial window resumes afterwards.
- Write side:
  - IDLE, wr=1: RAM[wptr]<=d, wptr<=wptr+1 with natural wrap.
  - fill<=fill+1, saturating at 2^P_NBITS_ADDR. fill needs P_NBITS_ADDR+1 bits.
- States: IDLE, READ.
- IDLE, trig=1:
  - len = min(n_pre, fill'), where fill' includes a same-cycle wr.
  - len==0: pulse trig_err next cycle, stay IDLE.
  - Otherwise:
    - Latch rptr = wptr' - len (mod depth) and remaining = len.
    - Go to READ; busy=1 from the next cycle.
    - The window's newest word is the sample written on the trig cycle if wr=1 there.
- READ:
  - Synchronous RAM read, 1-cycle latency, feeding a 2-entry output skid buffer.
  - First q_valid no later than 2 cycles after busy rises.
  - With q_ready held high: 1 word/cycle, no bubbles after the first.
  - Transfer occurs on q_valid && q_ready.
  - While q_valid=1 && q_ready=0, q and q_last hold stable.
  - q_valid never drops without a transfer.
  - q_last=1 exactly on the len-th word.
  - On transfer of the last word: state goes to IDLE and busy=0 on the next cycle. q_valid=0 unless a new window has started.
- wr during READ: sample discarded, wptr/fill unchanged, dropped pulses for 1 cycle per ignored wr.
- trig during READ is ignored, with no trig_err.
- Reads never see data newer than the window, because writes are frozen in READ.
- After READ, writes resume at the frozen wptr; fill is retained.
- Ordering: oldest first, wrapping from address depth-1 to 0.

Test Plan:
1. Reset, write d=1..10 (one per cycle), n_pre=4, trig with wr=0, q_ready=1 -> q=7,8,9,10; q_last only with 10; busy falls the cycle after 10 is accepted; no dropped or trig_err pulses.
2. Write d=1..10, then trig concurrent with wr of d=11, n_pre=4 -> q=8,9,10,11.
3. Window n_pre=8, q_ready pattern 1,0,1,0,... -> q stable through every stall; exactly 8 transfers in order, no duplicate or missing word; q_last on the 8th.
4. Clipping and reject:
   - After reset, write 1..3, n_pre=6 -> 3 words 1,2,3 with q_last on 3.
   - Fresh reset, trig with n_pre=5 and no writes -> trig_err single pulse, busy stays 0, q_valid stays 0.
5. Wrap: P_NBITS_ADDR=3 (depth 8), write 1..20, n_pre=7 -> q=14..20 across the address wrap. Then write 21,22, trig n_pre=3 -> 20,21,22.
6. Writes/trig during READ and reset mid-readout:
   - During a 4-word readout with q_ready=0, pulse wr 3 times -> 3 dropped pulses.
   - A second trig in the same readout is ignored.
   - A subsequent window excludes the dropped data.
   - Drop rst_n mid-READ -> q_valid, busy and q_last go 0 immediately; after release, trig with no new writes -> trig_err.
